// File: rtl/gpu_pkg.sv
// Shared types and constants for the frame-buffer arbiter and its round-robin picker.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_t;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_DRAW  = 2'd0;
    localparam logic [1:0] REQ_ALPHA = 2'd1;
    localparam logic [1:0] REQ_DISP  = 2'd2;

    // Requester index successor, wrapping modulo NUM_REQ.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection with a display-urgent override.
module rr_picker
    import gpu_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         rr_ptr,
    input  logic               urgent,
    output logic [1:0]         winner,
    output logic               valid,
    output logic               adv_ptr
);

    logic [1:0] cand1;
    logic [1:0] cand2;

    always_comb begin
        cand1   = next_idx(rr_ptr);
        cand2   = next_idx(cand1);
        winner  = REQ_DRAW;
        valid   = |req;
        adv_ptr = 1'b0;
        // An urgent display win leaves the rotation untouched.
        if (urgent && req[REQ_DISP]) begin
            winner = REQ_DISP;
        end else if (req[rr_ptr]) begin
            winner  = rr_ptr;
            adv_ptr = 1'b1;
        end else if (req[cand1]) begin
            winner  = cand1;
            adv_ptr = 1'b1;
        end else if (req[cand2]) begin
            winner  = cand2;
            adv_ptr = 1'b1;
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer SRAM arbiter for draw, alpha and display requesters.
// One transaction in flight; round-robin with a display-urgent override.
module frame_buffer_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata,
    input  logic                            disp_urgent,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rvalid,
    output logic [DATA_W-1:0]               rdata,
    output logic                            busy,
    output logic                            sram_en,
    output logic                            sram_we,
    output logic [ADDR_W-1:0]               sram_addr,
    output logic [DATA_W-1:0]               sram_wdata,
    input  logic [DATA_W-1:0]               sram_rdata,
    output arb_state_t                      dbg_state
);

    // Handshake: a requester raises req[i] with we/addr/wdata stable and holds
    // them until gnt[i] pulses; req is only sampled in IDLE, and a command that
    // has been captured always completes. Reads return later as an rvalid[i] pulse.

    localparam int               LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    arb_state_t       state;
    arb_state_t       state_d;
    logic [1:0]       rr_ptr;
    logic [1:0]       owner;
    logic [1:0]       winner;
    logic             pick_valid;
    logic             adv_ptr;
    logic [LAT_W-1:0] lat_cnt;
    logic             load_cmd;
    logic             load_lat;
    logic             capture;

    rr_picker u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .urgent  (disp_urgent),
        .winner  (winner),
        .valid   (pick_valid),
        .adv_ptr (adv_ptr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        load_cmd = 1'b0;
        load_lat = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = ACCESS;
                    load_cmd = 1'b1;
                end
            end
            ACCESS: begin
                // sram_we still carries the owner's direction during ACCESS.
                if (sram_we) begin
                    state_d = IDLE;
                end else begin
                    state_d  = RD_WAIT;
                    load_lat = 1'b1;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == '0) begin
                    state_d = IDLE;
                    capture = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr     <= REQ_DRAW;
            owner      <= REQ_DRAW;
            lat_cnt    <= '0;
            gnt        <= '0;
            rvalid     <= '0;
            rdata      <= '0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            gnt     <= '0;
            rvalid  <= '0;
            sram_en <= load_cmd;
            if (load_cmd) begin
                owner      <= winner;
                gnt        <= req_onehot(winner);
                sram_we    <= we[winner];
                sram_addr  <= addr[winner];
                sram_wdata <= wdata[winner];
                if (adv_ptr) begin
                    rr_ptr <= next_idx(winner);
                end
            end else begin
                sram_we <= 1'b0;
            end
            if (load_lat) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == RD_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (capture) begin
                rdata  <= sram_rdata;
                rvalid <= req_onehot(owner);
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
